// File: rtl/rock_ramp_scheduler_pkg.sv
// Shared types and constants for the rocking ramp scheduler: level width,
// default pacing, FSM state encoding and the work-ordering rule.
package rock_pkg;

  localparam int LVL_W          = 3;
  localparam int LVL_MAX        = (1 << LVL_W) - 1;
  localparam int STEP_TICKS_DEF = 4;
  localparam int HOLD_TICKS_DEF = 8;

  typedef logic [LVL_W-1:0] lvl_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_AMP_DN = 3'd1,
    ST_FREQ   = 3'd2,
    ST_AMP_UP = 3'd3,
    ST_HOLD   = 3'd4,
    ST_STOP   = 3'd5
  } state_e;

  // Amplitude is lowered before any frequency change and raised after it,
  // so the cradle never rocks at a new frequency with a higher amplitude.
  function automatic state_e first_work(lvl_t tgt_amp, lvl_t tgt_freq,
                                        lvl_t cur_amp, lvl_t cur_freq);
    state_e nxt;
    if (tgt_amp < cur_amp)        nxt = ST_AMP_DN;
    else if (tgt_freq != cur_freq) nxt = ST_FREQ;
    else if (tgt_amp > cur_amp)   nxt = ST_AMP_UP;
    else                          nxt = ST_HOLD;
    return nxt;
  endfunction

endpackage

// File: rtl/rock_ramp_scheduler_if.sv
// Target handshake between the rocking controller (master) and the scheduler (slave).
interface rock_ramp_scheduler_if;

  // A target transfers on a clock edge where tgt_valid and tgt_ready are both
  // high; the master holds tgt_valid/tgt_amp/tgt_freq stable until then, and
  // tgt_valid while tgt_ready is low has no effect.
  logic              tgt_valid;
  rock_pkg::lvl_t    tgt_amp;
  rock_pkg::lvl_t    tgt_freq;
  logic              tgt_ready;

  modport master (output tgt_valid, output tgt_amp, output tgt_freq, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_amp, input tgt_freq, output tgt_ready);

endinterface

// File: rtl/rock_ramp_scheduler_step_timer.sv
// Tick-qualified counter: done fires on the TERM-th enabled cycle since the last
// clear or done, and the count restarts from zero on that same edge.
module step_timer #(
  parameter int TERM = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int            CW   = (TERM > 1) ? $clog2(TERM) : 1;
  localparam logic [CW-1:0] LAST = CW'(TERM - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign done = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || done) cnt_d = '0;
    else if (en)     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rock_ramp_scheduler.sv
// Slews applied amplitude/frequency levels one step at a time toward an accepted
// target, and ramps both to zero (parking there) while a fault is present.
module rock_ramp_scheduler
  import rock_pkg::*;
#(
  parameter int STEP_TICKS = STEP_TICKS_DEF,
  parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  fault,
  rock_ramp_scheduler_if.slave  tgt,
  output lvl_t                  amp_out,
  output lvl_t                  freq_out,
  output logic                  busy,
  output logic                  parked,
  output state_e                dbg_state
);

  state_e state_q, state_d;
  lvl_t   amp_q, amp_d;
  lvl_t   freq_q, freq_d;
  lvl_t   tamp_q, tamp_d;
  lvl_t   tfreq_q, tfreq_d;
  logic   ready_q, ready_d;
  logic   busy_q, busy_d;
  logic   parked_q, parked_d;

  logic fault_preempt;
  logic stepping;
  logic step_en, step_done, step_clr;
  logic hold_en, hold_done, hold_clr;

  // A fault already being serviced must not freeze the ramp-down it started.
  assign fault_preempt = fault && (state_q != ST_STOP);
  assign stepping      = (state_q == ST_AMP_DN) || (state_q == ST_FREQ) ||
                         (state_q == ST_AMP_UP) ||
                         ((state_q == ST_STOP) && ((amp_q != '0) || (freq_q != '0)));
  assign step_en       = tick && !fault_preempt && stepping;
  assign hold_en       = tick && !fault_preempt && (state_q == ST_HOLD);
  assign step_clr      = (state_d != state_q);
  assign hold_clr      = (state_q != ST_HOLD);

  step_timer #(.TERM(STEP_TICKS)) u_step_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (step_clr),
    .en    (step_en),
    .done  (step_done)
  );

  step_timer #(.TERM(HOLD_TICKS)) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (hold_clr),
    .en    (hold_en),
    .done  (hold_done)
  );

  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    freq_d  = freq_q;
    tamp_d  = tamp_q;
    tfreq_d = tfreq_q;
    if (fault_preempt) begin
      state_d = ST_STOP;
      tamp_d  = '0;
      tfreq_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (tgt.tgt_valid && ready_q) begin
            tamp_d  = tgt.tgt_amp;
            tfreq_d = tgt.tgt_freq;
            state_d = first_work(tgt.tgt_amp, tgt.tgt_freq, amp_q, freq_q);
          end
        end
        ST_AMP_DN: begin
          if (step_done) begin
            amp_d = amp_q - 1'b1;
            if (amp_d == tamp_q) state_d = first_work(tamp_q, tfreq_q, amp_d, freq_q);
          end
        end
        ST_FREQ: begin
          if (step_done) begin
            freq_d = (tfreq_q > freq_q) ? freq_q + 1'b1 : freq_q - 1'b1;
            if (freq_d == tfreq_q) state_d = first_work(tamp_q, tfreq_q, amp_q, freq_d);
          end
        end
        ST_AMP_UP: begin
          if (step_done) begin
            amp_d = (amp_q == lvl_t'(LVL_MAX)) ? amp_q : amp_q + 1'b1;
            if (amp_d == tamp_q) state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_done) state_d = ST_IDLE;
        end
        ST_STOP: begin
          if (step_done) begin
            if (amp_q != '0) amp_d  = amp_q - 1'b1;
            else             freq_d = freq_q - 1'b1;
          end
          // Leave only once fully ramped down and the fault has cleared.
          if (!fault && (amp_d == '0) && (freq_d == '0)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    ready_d  = (state_d == ST_IDLE);
    parked_d = (state_d == ST_STOP) && (amp_d == '0) && (freq_d == '0) && fault;
    busy_d   = (state_d != ST_IDLE) && !parked_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      amp_q    <= '0;
      freq_q   <= '0;
      tamp_q   <= '0;
      tfreq_q  <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      parked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      amp_q    <= amp_d;
      freq_q   <= freq_d;
      tamp_q   <= tamp_d;
      tfreq_q  <= tfreq_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      parked_q <= parked_d;
    end
  end

  assign tgt.tgt_ready = ready_q;
  assign amp_out       = amp_q;
  assign freq_out      = freq_q;
  assign busy          = busy_q;
  assign parked        = parked_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rock_ramp_scheduler.sv
// Bench for rock_ramp_scheduler: directed scenarios plus random targets/faults,
// every cycle compared against a step-list reference model.
module tb_rock_ramp_scheduler;
  import rock_pkg::*;

  localparam int STEP  = 4;
  localparam int HOLD  = 8;
  localparam int BOUND = 4000;
  localparam int W     = 2 * LVL_W;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   tick = 1'b0;
  logic   fault = 1'b0;
  logic   tick_on = 1'b0;
  lvl_t   amp_out, freq_out;
  logic   busy, parked;
  state_e dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  rock_ramp_scheduler_if tgt_if ();

  rock_ramp_scheduler #(.STEP_TICKS(STEP), .HOLD_TICKS(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .fault     (fault),
    .tgt       (tgt_if),
    .amp_out   (amp_out),
    .freq_out  (freq_out),
    .busy      (busy),
    .parked    (parked),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- check task ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t state=%0d)", tag, obs, exp, $time, dbg_state);
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted target becomes a list of intermediate (amp,freq) levels; one
  // entry is applied every STEP ticks, then HOLD ticks pass before readiness.
  logic [W-1:0] exp_q[$];
  int m_amp, m_freq, m_cnt, m_hold;
  bit m_ready, m_stop, m_in_hold, m_parked;

  function automatic void model_reset();
    m_amp = 0; m_freq = 0; m_cnt = 0; m_hold = 0;
    m_ready = 1; m_stop = 0; m_in_hold = 0; m_parked = 0;
    exp_q.delete();
  endfunction

  function automatic void plan_target(input int ta, input int tf);
    int a = m_amp;
    int f = m_freq;
    exp_q.delete();
    while (a > ta) begin a--; exp_q.push_back({lvl_t'(a), lvl_t'(f)}); end
    while (f != tf) begin f += (tf > f) ? 1 : -1; exp_q.push_back({lvl_t'(a), lvl_t'(f)}); end
    while (a < ta) begin a++; exp_q.push_back({lvl_t'(a), lvl_t'(f)}); end
  endfunction

  function automatic void plan_down();
    int a = m_amp;
    int f = m_freq;
    exp_q.delete();
    while (a > 0) begin a--; exp_q.push_back({lvl_t'(a), lvl_t'(f)}); end
    while (f > 0) begin f--; exp_q.push_back({lvl_t'(a), lvl_t'(f)}); end
  endfunction

  function automatic void count_step();
    logic [W-1:0] e;
    m_cnt++;
    if (m_cnt == STEP) begin
      e = exp_q.pop_front();
      m_amp = int'(e[W-1:LVL_W]);
      m_freq = int'(e[LVL_W-1:0]);
      m_cnt = 0;
    end
  endfunction

  function automatic void model_step();
    if (fault && !m_stop) begin
      m_stop = 1; m_ready = 0; m_in_hold = 0; m_cnt = 0;
      plan_down();
    end else if (m_stop) begin
      if (exp_q.size() > 0 && tick) count_step();
      if (exp_q.size() == 0 && !fault) begin m_stop = 0; m_ready = 1; end
    end else if (m_ready) begin
      if (tgt_if.tgt_valid) begin
        plan_target(int'(tgt_if.tgt_amp), int'(tgt_if.tgt_freq));
        m_ready = 0; m_cnt = 0; m_hold = 0;
        m_in_hold = (exp_q.size() == 0);
      end
    end else if (!m_in_hold) begin
      if (tick) begin
        count_step();
        if (exp_q.size() == 0) begin m_in_hold = 1; m_hold = 0; end
      end
    end else if (tick) begin
      m_hold++;
      if (m_hold == HOLD) m_ready = 1;
    end
    m_parked = m_stop && (exp_q.size() == 0) && fault;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // ---------------- scoreboard (every cycle, away from the edge) ----------------
  bit saw_parked = 0;
  int max_amp = 0;

  initial forever begin
    @(negedge clk);
    check("amp_out",   amp_out,          m_amp);
    check("freq_out",  freq_out,         m_freq);
    check("tgt_ready", tgt_if.tgt_ready, m_ready);
    check("busy",      busy,             !m_ready && !m_parked);
    check("parked",    parked,           m_parked);
    if (parked) saw_parked = 1;
    if (int'(amp_out) > max_amp) max_amp = int'(amp_out);
  end

  // ---------------- stimulus ----------------
  initial forever begin
    @(negedge clk);
    tick = tick_on && ($urandom_range(0, 2) == 0);
  end

  task automatic send_target(input int a, input int f);
    int n = 0;
    @(negedge clk);
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_amp   = lvl_t'(a);
    tgt_if.tgt_freq  = lvl_t'(f);
    while (!tgt_if.tgt_ready && n < BOUND) begin @(negedge clk); n++; end
    check("accept_ready", tgt_if.tgt_ready, 1);
    @(negedge clk);
    tgt_if.tgt_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tgt_if.tgt_ready && n < BOUND) begin @(negedge clk); n++; end
    check("ready_reached", tgt_if.tgt_ready, 1);
  endtask

  task automatic wait_level(input bit is_amp, input int v);
    int n = 0;
    while (int'(is_amp ? amp_out : freq_out) != v && n < BOUND) begin @(negedge clk); n++; end
    check(is_amp ? "reach_amp" : "reach_freq", is_amp ? amp_out : freq_out, v);
  endtask

  initial begin
    tgt_if.tgt_valid = 1'b0;
    tgt_if.tgt_amp   = '0;
    tgt_if.tgt_freq  = '0;
    repeat (3) @(negedge clk);
    check("rst_amp", amp_out, 0);
    check("rst_freq", freq_out, 0);
    check("rst_ready", tgt_if.tgt_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_parked", parked, 0);
    reset = 1'b0;
    tick_on = 1'b1;

    // 0/0 -> 3/2: frequency first, then amplitude up, then hold.
    send_target(3, 2);
    wait_ready();
    check("s1_amp", amp_out, 3);
    check("s1_freq", freq_out, 2);

    // Target equal to current goes straight to hold.
    send_target(3, 2);
    wait_ready();
    check("eq_amp", amp_out, 3);

    // 5/4 -> 2/6: amplitude must come down before frequency moves.
    send_target(5, 4);
    wait_ready();
    max_amp = 0;
    send_target(2, 6);
    wait_ready();
    check("dn_amp_ceiling", max_amp, 5);
    check("dn_freq", freq_out, 6);

    // Fault pulse mid-FREQ at 3/4: ramp to zero, never park.
    send_target(3, 6);
    wait_ready();
    send_target(3, 2);
    wait_level(0, 4);
    saw_parked = 0;
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    wait_ready();
    check("pulse_no_park", saw_parked, 0);
    check("pulse_amp", amp_out, 0);
    check("pulse_freq", freq_out, 0);

    // Fault held: park at zero, ignore targets, release on fault drop.
    send_target(4, 3);
    wait_ready();
    fault = 1'b1;
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_amp   = lvl_t'(7);
    tgt_if.tgt_freq  = lvl_t'(7);
    for (int n = 0; n < BOUND && !parked; n++) @(negedge clk);
    check("held_parked", parked, 1);
    repeat (20) @(negedge clk);
    check("held_busy", busy, 0);
    check("held_ready", tgt_if.tgt_ready, 0);
    check("held_amp", amp_out, 0);
    tgt_if.tgt_valid = 1'b0;
    fault = 1'b0;
    @(negedge clk);
    check("release_ready", tgt_if.tgt_ready, 1);
    check("release_parked", parked, 0);

    // Asynchronous reset mid AMP_UP at amp=4.
    send_target(6, 1);
    wait_level(1, 4);
    #2 reset = 1'b1;
    #1;
    check("async_amp", amp_out, 0);
    check("async_freq", freq_out, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", tgt_if.tgt_ready, 1);

    // Random targets, held while busy, with occasional fault pulses/holds.
    for (int i = 0; i < 30; i++) begin
      send_target($urandom_range(0, LVL_MAX), $urandom_range(0, LVL_MAX));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 80)) @(negedge clk);
        fault = 1'b1;
        repeat (($urandom_range(0, 1) == 0) ? 1 : $urandom_range(50, 200)) @(negedge clk);
        fault = 1'b0;
      end
    end
    wait_ready();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
